fifo_bram_flagged: RTL and testbench

//   Parametrised block-RAM FIFO with inferred storage (no vendor scfifo macro), any depth >= 2
//   (power of 2 not required), occupancy count, programmable almostFull/almostEmpty, and sticky

---
 rtl/fifo_bram_flagged_if.sv | 32 +++
 rtl/fifo_bram_flagged.sv | 93 +++++++++
 tb/tb_fifo_bram_flagged.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fifo_bram_flagged_if.sv
// Enqueue/dequeue handshake bundle for fifo_bram_flagged.
// master = producer/consumer side, slave = the FIFO.
interface fifo_bram_flagged_if #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 16
);
  localparam int CW = $clog2(N_ENTRIES + 1);

  logic [N_DATA_BITS-1:0] enq_data;
  logic                   enq_en;
  logic                   notFull;
  logic                   almostFull;
  logic [N_DATA_BITS-1:0] first;
  logic                   deq_en;
  logic                   notEmpty;
  logic                   almostEmpty;
  logic [CW-1:0]          count;
  logic                   err_overflow;
  logic                   err_underflow;

  modport master (
    output enq_data, enq_en, deq_en,
    input  notFull, almostFull, first, notEmpty, almostEmpty, count,
           err_overflow, err_underflow
  );

  modport slave (
    input  enq_data, enq_en, deq_en,
    output notFull, almostFull, first, notEmpty, almostEmpty, count,
           err_overflow, err_underflow
  );
endinterface

// File: rtl/fifo_bram_flagged.sv
// Inferred-BRAM FIFO, any depth >= 2, with occupancy, almost flags and sticky error flags.
// The registered BRAM read port doubles as the head-of-queue register (first).
module fifo_bram_flagged #(
  parameter int N_DATA_BITS  = 32,
  parameter int N_ENTRIES    = 16,
  parameter int THRESHOLD    = 1,
  parameter int AE_THRESHOLD = 1
) (
  input logic               clk,
  input logic               reset_n,
  fifo_bram_flagged_if.slave bus
);
  localparam int CW = $clog2(N_ENTRIES + 1);
  localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(N_ENTRIES);
  localparam logic [PW-1:0] LAST_PTR = PW'(N_ENTRIES - 1);

  if (N_ENTRIES < 2 || THRESHOLD < 0 || THRESHOLD >= N_ENTRIES ||
      AE_THRESHOLD < 0 || AE_THRESHOLD >= N_ENTRIES) begin : g_bad_params
    $error("fifo_bram_flagged: illegal parameter combination");
  end

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [N_DATA_BITS-1:0] first_q;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   head_vld;
  logic                   err_ovf, err_udf;

  logic not_full, bram_full, bram_nonempty;
  logic enq_acc, deq_acc, rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Words in the array = total count minus the one parked in first_q.
  assign bram_full     = (count - CW'(head_vld)) == FULL_CNT;
  assign bram_nonempty = (wr_ptr != rd_ptr) || bram_full;
  assign not_full      = count != FULL_CNT;
  assign enq_acc       = bus.enq_en && not_full;
  assign deq_acc       = bus.deq_en && head_vld;
  assign rd            = (!head_vld || bus.deq_en) && bram_nonempty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      if (enq_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd)      rd_ptr <= next_ptr(rd_ptr);
      head_vld <= (head_vld && !bus.deq_en) || rd;
      case ({enq_acc, deq_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.enq_en && !not_full) err_ovf <= 1'b1;
      if (bus.deq_en && !head_vld) err_udf <= 1'b1;
    end
  end

  // Storage and read register carry no reset, so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (reset_n && enq_acc) mem[wr_ptr] <= bus.enq_data;
  end

  always_ff @(posedge clk) begin
    if (reset_n && rd) first_q <= mem[rd_ptr];
  end

  assign bus.notFull       = not_full;
  assign bus.almostFull    = (FULL_CNT - count) <= CW'(THRESHOLD);
  assign bus.almostEmpty   = count <= CW'(AE_THRESHOLD);
  assign bus.first         = first_q;
  assign bus.notEmpty      = head_vld;
  assign bus.count         = count;
  assign bus.err_overflow  = err_ovf;
  assign bus.err_underflow = err_udf;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count <= FULL_CNT);
      assert (!head_vld || count != '0);
    end
  end
`endif
endmodule

// File: tb/tb_fifo_bram_flagged.sv
// Directed and randomized checks of fifo_bram_flagged against a queue-based reference.
module tb_fifo_bram_flagged;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  fifo_bram_flagged_if #(.N_DATA_BITS(32), .N_ENTRIES(8)) b8 ();
  fifo_bram_flagged_if #(.N_DATA_BITS(32), .N_ENTRIES(5)) b5 ();

  fifo_bram_flagged #(.N_DATA_BITS(32), .N_ENTRIES(8), .THRESHOLD(1), .AE_THRESHOLD(1))
    dut8 (.clk(clk), .reset_n(reset_n), .bus(b8));
  fifo_bram_flagged #(.N_DATA_BITS(32), .N_ENTRIES(5), .THRESHOLD(1), .AE_THRESHOLD(1))
    dut5 (.clk(clk), .reset_n(reset_n), .bus(b5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    int nxt, received;
    logic e, d, deq_ok, enq_ok;

    b8.enq_en = 0; b8.deq_en = 0; b8.enq_data = '0;
    b5.enq_en = 0; b5.deq_en = 0; b5.enq_data = '0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;

    // reset state
    chk("rst_count", b8.count, 0);
    chk("rst_notEmpty", b8.notEmpty, 0);
    chk("rst_notFull", b8.notFull, 1);
    chk("rst_almostFull", b8.almostFull, 0);
    chk("rst_almostEmpty", b8.almostEmpty, 1);
    chk("rst_err_ovf", b8.err_overflow, 0);
    chk("rst_err_udf", b8.err_underflow, 0);

    // first-word latency
    b8.enq_en = 1; b8.enq_data = 32'hA5;
    tick();
    b8.enq_en = 0;
    chk("lat_c1_notEmpty", b8.notEmpty, 0);
    chk("lat_c1_count", b8.count, 1);
    tick();
    chk("lat_c2_notEmpty", b8.notEmpty, 1);
    chk("lat_c2_first", b8.first, 32'hA5);
    chk("lat_c2_count", b8.count, 1);
    b8.deq_en = 1;
    tick();
    b8.deq_en = 0;
    chk("lat_drain_count", b8.count, 0);
    chk("lat_drain_notEmpty", b8.notEmpty, 0);

    // underflow
    b8.deq_en = 1;
    tick();
    b8.deq_en = 0;
    chk("udf_flag", b8.err_underflow, 1);
    chk("udf_count", b8.count, 0);
    chk("udf_notEmpty", b8.notEmpty, 0);
    b8.enq_en = 1; b8.enq_data = 32'h77;
    tick();
    b8.enq_en = 0;
    tick();
    chk("udf_next_first", b8.first, 32'h77);
    chk("udf_sticky", b8.err_underflow, 1);
    b8.deq_en = 1;
    tick();
    b8.deq_en = 0;
    chk("udf_drain_count", b8.count, 0);

    // fill to full, watch almostFull/notFull
    for (int k = 0; k < 8; k++) begin
      b8.enq_en = 1; b8.enq_data = 32'h10 + k;
      tick();
      chk("fill_count", b8.count, k + 1);
      chk("fill_almostFull", b8.almostFull, (k + 1) >= 7);
      chk("fill_notFull", b8.notFull, (k + 1) != 8);
    end
    b8.enq_en = 0;
    chk("full_first", b8.first, 32'h10);
    chk("full_err_ovf_clear", b8.err_overflow, 0);

    // enq+deq while full: deq wins, enq dropped and flagged
    b8.enq_en = 1; b8.enq_data = 32'h99; b8.deq_en = 1;
    tick();
    b8.enq_en = 0; b8.deq_en = 0;
    chk("full_ed_count", b8.count, 7);
    chk("full_ed_ovf", b8.err_overflow, 1);
    chk("full_ed_first", b8.first, 32'h11);
    for (int v = 32'h11; v <= 32'h17; v++) begin
      chk("drain_first", b8.first, v);
      chk("drain_notEmpty", b8.notEmpty, 1);
      b8.deq_en = 1;
      tick();
    end
    b8.deq_en = 0;
    chk("drain_count", b8.count, 0);
    chk("drain_empty", b8.notEmpty, 0);

    // reset mid-operation
    for (int k = 0; k < 6; k++) begin
      b8.enq_en = 1; b8.enq_data = 32'h40 + k;
      tick();
    end
    b8.enq_en = 0;
    chk("mid_count6", b8.count, 6);
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("mid_rst_count", b8.count, 0);
    chk("mid_rst_notEmpty", b8.notEmpty, 0);
    chk("mid_rst_ovf", b8.err_overflow, 0);
    chk("mid_rst_udf", b8.err_underflow, 0);
    chk("mid_rst_notFull", b8.notFull, 1);
    b8.enq_en = 1; b8.enq_data = 32'h33;
    tick();
    b8.enq_en = 0;
    tick();
    chk("mid_rst_first", b8.first, 32'h33);
    chk("mid_rst_count1", b8.count, 1);

    // randomized traffic on the 5-deep instance
    nxt = 0; received = 0;
    for (int cyc = 0; cyc < 3000 && received < 40; cyc++) begin
      chk("rnd_count", b5.count, q.size());
      chk("rnd_count_le", b5.count <= 5, 1);
      chk("rnd_almostEmpty", b5.almostEmpty, q.size() <= 1);
      if (b5.notEmpty) begin
        if (q.size() > 0) chk("rnd_first", b5.first, q[0]);
        else              chk("rnd_spurious_ne", b5.notEmpty, 0);
      end
      e = (nxt < 40) && ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 1) == 1);
      b5.enq_en = e; b5.enq_data = nxt; b5.deq_en = d;
      deq_ok = d && b5.notEmpty && (q.size() > 0);
      enq_ok = e && (q.size() < 5);
      if (deq_ok) begin
        void'(q.pop_front());
        received++;
      end
      if (enq_ok) begin
        q.push_back(nxt);
        nxt++;
      end
      tick();
    end
    b5.enq_en = 0; b5.deq_en = 0;
    chk("rnd_all_received", received, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
